// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - two-read operand sequencer, B shifter and ALU with register file write-back
// Optional status flags: define ALU_SEQ_STATUS_EN to build the Z/N/V registers.
`timescale 1ns/1ps

module alu_sequencer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [1:0]   shift,
    input  logic [2:0]   rd,
    input  logic [2:0]   rn,
    input  logic [2:0]   rm,
    input  logic [W-1:0] rf_rdata,
    output logic [2:0]   readnum,
    output logic [2:0]   writenum,
    output logic         write,
    output logic [W-1:0] rf_wdata,
    output logic [W-1:0] result,
    output logic         busy,
    output logic         done,
    output logic         Z,
    output logic         N,
    output logic         V
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_A,
        S_READ_B,
        S_EXEC,
        S_WRITE
    } state_t;

    state_t       state;
    logic [1:0]   op_q;
    logic [1:0]   shift_q;
    logic [2:0]   rd_q;
    logic [2:0]   rm_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] c_q;

    logic [W-1:0] sb;
    logic         is_sub;
    logic [W-1:0] addend;
    logic [W-1:0] sum;
    logic [W-1:0] alu_y;

    always_comb begin
        case (shift_q)
            2'b01:   sb = {b_q[W-2:0], 1'b0};
            2'b10:   sb = {1'b0, b_q[W-1:1]};
            2'b11:   sb = {b_q[W-1], b_q[W-1:1]};
            default: sb = b_q;
        endcase
        is_sub = (op_q == 2'b01);
        // Subtract as A + ~sB + 1 so ADD and SUB share one adder
        addend = is_sub ? ~sb : sb;
        sum    = a_q + addend + {{(W-1){1'b0}}, is_sub};
        case (op_q)
            2'b10:   alu_y = a_q & sb;
            2'b11:   alu_y = ~sb;
            default: alu_y = sum;
        endcase
    end

    // Control outputs are registered alongside the state so they decode cleanly off the clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= '0;
            shift_q  <= '0;
            rd_q     <= '0;
            rm_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            readnum  <= '0;
            writenum <= '0;
            write    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        shift_q <= shift;
                        rd_q    <= rd;
                        rm_q    <= rm;
                        readnum <= rn;
                        busy    <= 1'b1;
                        state   <= S_READ_A;
                    end
                end
                S_READ_A: begin
                    a_q     <= rf_rdata;
                    readnum <= rm_q;
                    state   <= S_READ_B;
                end
                S_READ_B: begin
                    b_q     <= rf_rdata;
                    readnum <= '0;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    c_q      <= alu_y;
                    write    <= 1'b1;
                    writenum <= rd_q;
                    done     <= 1'b1;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    write    <= 1'b0;
                    writenum <= '0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    readnum  <= '0;
                    writenum <= '0;
                    write    <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign result   = c_q;
    assign rf_wdata = c_q;

`ifdef ALU_SEQ_STATUS_EN
    logic z_q;
    logic n_q;
    logic v_q;
    logic alu_v;

    // Overflow when both adder inputs share a sign the sum does not
    assign alu_v = !op_q[1] && (a_q[W-1] == addend[W-1]) && (sum[W-1] != a_q[W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (state == S_EXEC) begin
            z_q <= (alu_y == '0);
            n_q <= alu_y[W-1];
            v_q <= alu_v;
        end
    end

    assign Z = z_q;
    assign N = n_q;
    assign V = v_q;
`else
    assign Z = 1'b0;
    assign N = 1'b0;
    assign V = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer with a behavioural register file
`timescale 1ns/1ps

module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [1:0]  shift = '0;
    logic [2:0]  rd = '0;
    logic [2:0]  rn = '0;
    logic [2:0]  rm = '0;
    logic [15:0] rf_rdata;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [15:0] rf_wdata;
    logic [15:0] result;
    logic        busy;
    logic        done;
    logic        Z;
    logic        N;
    logic        V;

    logic [15:0] rf [8];
    logic        poke = 1'b0;
    logic [2:0]  poke_addr = '0;
    logic [15:0] poke_data = '0;

    int n_vec = 0;
    int n_err = 0;

    alu_sequencer #(.W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .shift(shift),
        .rd(rd), .rn(rn), .rm(rm), .rf_rdata(rf_rdata), .readnum(readnum),
        .writenum(writenum), .write(write), .rf_wdata(rf_wdata), .result(result),
        .busy(busy), .done(done), .Z(Z), .N(N), .V(V)
    );

    always #5 clk = ~clk;

    assign rf_rdata = rf[readnum];

    always @(posedge clk) begin
        if (write)
            rf[writenum] <= rf_wdata;
        else if (poke)
            rf[poke_addr] <= poke_data;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_reg(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        poke = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke = 1'b0;
    endtask

    // Reference: signed arithmetic on whole integers, overflow = result outside 16-bit signed range
    task automatic model(input logic [1:0] mop, input logic [1:0] msh, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] y, output logic [2:0] znv);
        logic [15:0] sb;
        int sa, ssb, r;
        logic ov;
        case (msh)
            2'd1:    sb = b << 1;
            2'd2:    sb = b >> 1;
            2'd3:    sb = $signed(b) >>> 1;
            default: sb = b;
        endcase
        sa = $signed(a);
        ssb = $signed(sb);
        ov = 1'b0;
        case (mop)
            2'd0:    begin r = sa + ssb; ov = (r > 32767) || (r < -32768); y = r[15:0]; end
            2'd1:    begin r = sa - ssb; ov = (r > 32767) || (r < -32768); y = r[15:0]; end
            2'd2:    y = a & sb;
            default: y = ~sb;
        endcase
`ifdef ALU_SEQ_STATUS_EN
        znv = {(y == 16'h0), y[15], ov};
`else
        znv = 3'b000;
`endif
    endtask

    task automatic run_op(input string tag, input logic [1:0] mop, input logic [1:0] msh,
                          input logic [2:0] mrd, input logic [2:0] mrn, input logic [2:0] mrm);
        logic [15:0] exp_y;
        logic [2:0]  exp_f;
        int cnt;
        model(mop, msh, rf[mrn], rf[mrm], exp_y, exp_f);
        @(negedge clk);
        op = mop; shift = msh; rd = mrd; rn = mrn; rm = mrm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".readnum_a"}, readnum, mrn);
        check({tag, ".busy"}, busy, 1);
        @(negedge clk);
        check({tag, ".readnum_b"}, readnum, mrm);
        cnt = 2;
        while (!done && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, ".latency"}, cnt, 4);
        check({tag, ".write"}, {write, writenum}, {1'b1, mrd});
        check({tag, ".result"}, result, exp_y);
        check({tag, ".flags"}, {Z, N, V}, exp_f);
        @(negedge clk);
        check({tag, ".idle"}, {busy, write, done}, 3'b000);
        check({tag, ".rf"}, rf[mrd], exp_y);
    endtask

    initial begin
        int wr_cnt;
        logic sticky;
        logic [15:0] keep;
        logic [15:0] exp_b2b;
        logic [2:0]  f_b2b;
        int done_at[$];

        repeat (3) @(negedge clk);
        check("reset.outputs", {readnum, writenum, write, rf_wdata, result, busy, done, Z, N, V}, '0);
        for (int i = 0; i < 8; i++) set_reg(i[2:0], 16'($urandom));
        rst_n = 1'b1;
        sticky = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            sticky |= busy | write;
        end
        check("reset.idle10", sticky, 0);

        set_reg(1, 16'd5); set_reg(2, 16'd3);
        run_op("add", 2'b00, 2'b00, 3, 1, 2);
        check("add.r3", rf[3], 16'd8);
        set_reg(4, 16'h0010); set_reg(5, 16'h0008);
        run_op("sub0", 2'b01, 2'b01, 6, 4, 5);
        check("sub0.r6", rf[6], 16'h0000);
        set_reg(0, 16'h7FFF); set_reg(1, 16'h0001);
        run_op("ovf", 2'b00, 2'b00, 0, 0, 1);
        check("ovf.r0", rf[0], 16'h8000);
        run_op("mvn", 2'b11, 2'b11, 0, 0, 0);
        check("mvn.r0", rf[0], 16'h3FFF);

        for (int k = 0; k < 25; k++) begin
            if (k % 5 == 0) set_reg(3'($urandom), 16'($urandom_range(0, 1)) ? 16'h8000 : 16'($urandom));
            run_op("rand", 2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
        end

        // Start pulsed in READ_B must not launch a second operation
        @(negedge clk);
        op = 2'b00; shift = 2'b00; rd = 7; rn = 1; rm = 2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (write) wr_cnt++;
        end
        check("midstart.writes", wr_cnt, 1);
        check("midstart.busy", busy, 0);

        // Reset during EXEC abandons the operation
        set_reg(7, 16'hA5A5);
        keep = rf[7];
        @(negedge clk);
        op = 2'b10; rd = 7; rn = 1; rm = 2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_exec.outputs", {busy, write, done, result}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_cnt = 0;
        sticky = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (write) wr_cnt++;
            sticky |= busy;
        end
        check("rst_exec.writes", wr_cnt, 0);
        check("rst_exec.busy", sticky, 0);
        check("rst_exec.r7", rf[7], keep);

        // Back-to-back with start held; rd disjoint from sources so all three results match
        set_reg(2, 16'h1234); set_reg(3, 16'h0101);
        model(2'b01, 2'b10, rf[2], rf[3], exp_b2b, f_b2b);
        @(negedge clk);
        op = 2'b01; shift = 2'b10; rd = 5; rn = 2; rm = 3; start = 1'b1;
        wr_cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (done) done_at.push_back(c);
            if (write) wr_cnt++;
            if (c == 14) start = 1'b0;
        end
        check("b2b.count", done_at.size(), 3);
        if (done_at.size() == 3) begin
            check("b2b.done0", done_at[0], 4);
            check("b2b.done1", done_at[1], 9);
            check("b2b.done2", done_at[2], 14);
        end
        check("b2b.writes", wr_cnt, 3);
        check("b2b.r5", rf[5], exp_b2b);
        check("b2b.flags", {Z, N, V}, f_b2b);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
